// File: rtl/seg_digit_entry.sv
// seg_digit_entry: seven-segment decimal keypad entry with multi-cycle BCD-to-binary conversion
module seg_digit_entry #(
    parameter int MAX_DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_in,
    input  logic        seg_valid,
    input  logic        del,
    input  logic        enter,
    input  logic        clr,
    output logic [31:0] value,
    output logic        value_valid,
    output logic        busy,
    output logic [2:0]  digit_count,
    output logic [15:0] digits,
    output logic        bad_seg,
    output logic        overflow
);
    typedef enum logic [1:0] {IDLE, ENTRY, CONV, DONE} state_t;

    state_t      state, state_n;
    logic [15:0] digits_n;
    logic [2:0]  count_n;
    logic [13:0] acc, acc_n;
    logic [1:0]  step, step_n;
    logic [31:0] value_n;
    logic        vv_n, bad_n, ovf_n;
    logic        legal;
    logic [3:0]  dec, nib;

    // Reverse the display encoding: bit 4 flags a legal code, low nibble is the digit
    function automatic logic [4:0] decode(input logic [7:0] c);
        case (c)
            8'hFC: decode = 5'h10;
            8'h60: decode = 5'h11;
            8'hDA: decode = 5'h12;
            8'hF2: decode = 5'h13;
            8'h66: decode = 5'h14;
            8'hB6: decode = 5'h15;
            8'h3E: decode = 5'h16;
            8'hE0: decode = 5'h17;
            8'hFE: decode = 5'h18;
            8'hE6: decode = 5'h19;
            default: decode = 5'h00;
        endcase
    endfunction

    assign {legal, dec} = decode(seg_in);
    assign nib  = digits[{~step, 2'b00} +: 4];
    assign busy = (state == CONV) || (state == DONE);

    // Next-state and next-register computation; key strobes resolve clr > enter > del > seg_valid
    always_comb begin
        state_n  = state;
        digits_n = digits;
        count_n  = digit_count;
        acc_n    = acc;
        step_n   = step;
        value_n  = value;
        vv_n     = 1'b0;
        bad_n    = 1'b0;
        ovf_n    = 1'b0;
        case (state)
            IDLE, ENTRY: begin
                if (clr) begin
                    digits_n = '0;
                    count_n  = '0;
                    state_n  = IDLE;
                end else if (enter) begin
                    acc_n   = '0;
                    step_n  = '0;
                    state_n = CONV;
                end else if (del) begin
                    if (digit_count != 3'd0) begin
                        digits_n = {4'h0, digits[15:4]};
                        count_n  = digit_count - 3'd1;
                        state_n  = (digit_count == 3'd1) ? IDLE : ENTRY;
                    end
                end else if (seg_valid) begin
                    if (!legal) begin
                        bad_n = 1'b1;
                    end else if (digit_count == 3'(MAX_DIGITS)) begin
                        ovf_n = 1'b1;
                    end else begin
                        digits_n = {digits[11:0], dec};
                        count_n  = digit_count + 3'd1;
                        state_n  = ENTRY;
                    end
                end
            end
            CONV: begin
                if (clr) begin
                    digits_n = '0;
                    count_n  = '0;
                    state_n  = IDLE;
                end else begin
                    acc_n   = (acc << 3) + (acc << 1) + {10'b0, nib};
                    step_n  = step + 2'd1;
                    state_n = (step == 2'd3) ? DONE : CONV;
                end
            end
            default: begin
                value_n  = {18'b0, acc};
                vv_n     = 1'b1;
                digits_n = '0;
                count_n  = '0;
                state_n  = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            digits      <= '0;
            digit_count <= '0;
            acc         <= '0;
            step        <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            bad_seg     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            digits      <= digits_n;
            digit_count <= count_n;
            acc         <= acc_n;
            step        <= step_n;
            value       <= value_n;
            value_valid <= vv_n;
            bad_seg     <= bad_n;
            overflow    <= ovf_n;
        end
    end
endmodule
